hilo_mul_ctrl: RTL

EX-stage issue and retire controller for multiply instructions, sitting between the EX decode/operand path and `multiplier_control`. It converts MULT/MULTU operands to magnitude-plus-sign form and issues a one-cycle `mul_begin`. It stalls EX until `mul_done` pulses, then writes the 64-bit product into the architectural HI/LO registers. It also executes MTHI/MTLO and handles exception flushes of an in-flight multiply.

---
 rtl/hilo_mul_ctrl_pkg.sv | 41 ++++
 rtl/hilo_mul_ctrl_if.sv | 21 ++
 rtl/hilo_mul_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/hilo_mul_ctrl_pkg.sv
// Shared types for the HI/LO multiply issue/retire controller: opcodes, FSM states,
// the multiplier operand payload and the magnitude/sign conversion helper.
package hilo_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ST_W   = 2;
    localparam int unsigned PROD_W = 2 * XLEN;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_MTHI  = 3'd3,
        OP_MTLO  = 3'd4
    } hilo_op_t;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } hilo_state_t;

    typedef struct packed {
        logic            sign;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } mul_operands_t;

    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    function automatic mul_operands_t mul_abs_sign(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic            is_signed);
        mul_operands_t r;
        r.sign = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
        r.a    = (is_signed & a[XLEN-1]) ? XLEN'(-a) : a;
        r.b    = (is_signed & b[XLEN-1]) ? XLEN'(-b) : b;
        return r;
    endfunction

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// Start/operand/result handshake between the HI/LO controller and multiplier_control.
interface hilo_mul_if;
    import hilo_pkg::*;

    logic              mul_begin;
    logic              mul_sign;
    logic [XLEN-1:0]   mul_a;
    logic [XLEN-1:0]   mul_b;
    logic [PROD_W-1:0] mul_res;
    logic              mul_done;

    modport master (
        output mul_begin, mul_sign, mul_a, mul_b,
        input  mul_res, mul_done
    );

    modport slave (
        input  mul_begin, mul_sign, mul_a, mul_b,
        output mul_res, mul_done
    );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// EX-stage multiply issue/retire controller: issues MULT/MULTU to the multiplier,
// stalls EX until completion, owns architectural HI/LO and executes MTHI/MTLO.
module hilo_mul_ctrl
    import hilo_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_HI = 32'h0,
    parameter logic [XLEN-1:0] RESET_LO = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [OP_W-1:0] ex_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic            flush,
    output logic            stall,
    hilo_mul_if.master      mul,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [ST_W-1:0] S_IDLE  = ST_W'(ST_IDLE);
    localparam logic [ST_W-1:0] S_BUSY  = ST_W'(ST_BUSY);
    localparam logic [ST_W-1:0] S_DRAIN = ST_W'(ST_DRAIN);

    logic [ST_W-1:0] state_q, state_d;
    logic            mul_begin_q, mul_begin_d;
    mul_operands_t   ops_q, ops_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            is_mult, is_mul_op, issue, stall_c, ex_commit;

    // Issue decode, stall and next-state/register update.
    always_comb begin
        state_d     = state_q;
        mul_begin_d = 1'b0;
        ops_d       = ops_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        is_mult   = (ex_op == OP_W'(OP_MULT));
        is_mul_op = ex_valid & (is_mult | (ex_op == OP_W'(OP_MULTU)));
        issue     = (state_q == S_IDLE) & is_mul_op & ~flush;
        stall_c   = ~rst & (issue
                            | ((state_q == S_BUSY) & ~mul.mul_done & ~flush)
                            | ((state_q == S_DRAIN) & is_mul_op));
        ex_commit = ex_valid & ~flush & ~stall_c;

        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d     = S_BUSY;
                    mul_begin_d = 1'b1;
                    ops_d       = mul_abs_sign(ex_a, ex_b, is_mult);
                end
            end
            S_BUSY: begin
                // The multiplier cannot be cancelled; a flush before done waits it out in DRAIN.
                if (flush) begin
                    state_d = mul.mul_done ? S_IDLE : S_DRAIN;
                end else if (mul.mul_done) begin
                    state_d = S_IDLE;
                    hi_d    = mul.mul_res[PROD_W-1:XLEN];
                    lo_d    = mul.mul_res[XLEN-1:0];
                end
            end
            S_DRAIN: begin
                if (mul.mul_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ex_commit && ex_op == OP_W'(OP_MTHI)) begin
            hi_d = ex_a;
        end
        if (ex_commit && ex_op == OP_W'(OP_MTLO)) begin
            lo_d = ex_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mul_begin_q <= 1'b0;
            ops_q       <= '0;
            hi_q        <= RESET_HI;
            lo_q        <= RESET_LO;
        end else begin
            state_q     <= state_d;
            mul_begin_q <= mul_begin_d;
            ops_q       <= ops_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign stall         = stall_c;
    assign mul.mul_begin = mul_begin_q;
    assign mul.mul_sign  = ops_q.sign;
    assign mul.mul_a     = ops_q.a;
    assign mul.mul_b     = ops_q.b;
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule
